irq_arbiter: RTL and testbench



---
 rtl/irq_arbiter.sv | 109 ++++++++++
 tb/tb_irq_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/irq_arbiter.sv
// Fixed-priority interrupt arbiter with request/ack handshake and no nesting.
// Define IRQ_EDGE_DETECT_EN for edge capture with sticky pending; default is level mode.
module irq_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int ID_W    = $clog2(NUM_SRC)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic [NUM_SRC-1:0] mie_mask,
    input  logic               mstatus_mie,
    input  logic               trap_ack,
    input  logic               mret_done,
    output logic               interrupt,
    output logic [ID_W-1:0]    irq_id,
    output logic [31:0]        irq_cause,
    output logic [NUM_SRC-1:0] pending,
    output logic               in_service
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] REQ     = 2'd1;
    localparam logic [1:0] SERVICE = 2'd2;

    logic [1:0]         state;
    logic [NUM_SRC-1:0] eligible;
    logic [ID_W-1:0]    winner;

    assign eligible = mstatus_mie ? (pending & mie_mask) : '0;

    // Scan high to low so the lowest set index is the one left standing.
    always_comb begin
        winner = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner = ID_W'(i);
            end
        end
    end

`ifdef IRQ_EDGE_DETECT_EN
    logic [NUM_SRC-1:0] src_hist;
    logic [NUM_SRC-1:0] set_mask;
    logic [NUM_SRC-1:0] clr_mask;

    assign set_mask = irq_src & ~src_hist;

    always_comb begin
        clr_mask = '0;
        if (state == REQ && trap_ack) begin
            clr_mask[irq_id] = 1'b1;
        end
    end

    // A fresh edge on the bit being acknowledged survives the clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            src_hist <= '0;
            pending  <= '0;
        end else begin
            src_hist <= irq_src;
            pending  <= (pending & ~clr_mask) | set_mask;
        end
    end
`else
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= '0;
        end else begin
            pending <= irq_src;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            irq_id <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|eligible) begin
                        irq_id <= winner;
                        state  <= REQ;
                    end
                end
                REQ: begin
                    // Acknowledge beats withdrawal when both land together.
                    if (trap_ack) begin
                        state <= SERVICE;
                    end else if (!eligible[irq_id]) begin
                        state <= IDLE;
                    end
                end
                SERVICE: begin
                    if (mret_done) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign interrupt  = (state == REQ);
    assign in_service = (state == SERVICE);
    assign irq_cause  = {1'b1, 31'(32'd16 + 32'(irq_id))};

endmodule

// File: tb/tb_irq_arbiter.sv
// Directed bench for irq_arbiter; exercises edge or level capture depending on IRQ_EDGE_DETECT_EN.
module tb_irq_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] irq_src;
    logic [3:0] mie_mask;
    logic       mstatus_mie;
    logic       trap_ack;
    logic       mret_done;
    logic       interrupt;
    logic [1:0] irq_id;
    logic [31:0] irq_cause;
    logic [3:0] pending;
    logic       in_service;

    int vectors;
    int miscompares;

    irq_arbiter #(.NUM_SRC(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .irq_src     (irq_src),
        .mie_mask    (mie_mask),
        .mstatus_mie (mstatus_mie),
        .trap_ack    (trap_ack),
        .mret_done   (mret_done),
        .interrupt   (interrupt),
        .irq_id      (irq_id),
        .irq_cause   (irq_cause),
        .pending     (pending),
        .in_service  (in_service)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic e_int, input logic [1:0] e_id,
                              input logic [3:0] e_pend, input logic e_svc);
        chk({tag, ".interrupt"}, 32'(interrupt), 32'(e_int));
        chk({tag, ".irq_id"}, 32'(irq_id), 32'(e_id));
        chk({tag, ".irq_cause"}, irq_cause, 32'h8000_0010 + 32'(e_id));
        chk({tag, ".pending"}, 32'(pending), 32'(e_pend));
        chk({tag, ".in_service"}, 32'(in_service), 32'(e_svc));
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        irq_src     = 4'b0000;
        mie_mask    = 4'b1111;
        mstatus_mie = 1'b1;
        trap_ack    = 1'b0;
        mret_done   = 1'b0;
        #3;
        expect_out("reset", 1'b0, 2'd0, 4'b0000, 1'b0);
        tick;
        tick;
        #2 rst = 1'b1;
        tick;
        expect_out("post_reset_idle", 1'b0, 2'd0, 4'b0000, 1'b0);

        // trap_ack / mret_done in IDLE must be ignored
        trap_ack = 1'b1; mret_done = 1'b1;
        tick;
        expect_out("idle_ignore", 1'b0, 2'd0, 4'b0000, 1'b0);
        trap_ack = 1'b0; mret_done = 1'b0;

`ifdef IRQ_EDGE_DETECT_EN
        // single pulse on source 2
        irq_src = 4'b0100; tick;
        expect_out("e1_capture", 1'b0, 2'd0, 4'b0100, 1'b0);
        irq_src = 4'b0000; tick;
        expect_out("e1_req", 1'b1, 2'd2, 4'b0100, 1'b0);
        trap_ack = 1'b1; tick;
        expect_out("e1_ack", 1'b0, 2'd2, 4'b0000, 1'b1);
        trap_ack = 1'b0; tick;
        expect_out("e1_hold", 1'b0, 2'd2, 4'b0000, 1'b1);
        mret_done = 1'b1; tick;
        expect_out("e1_mret", 1'b0, 2'd2, 4'b0000, 1'b0);
        mret_done = 1'b0;

        // simultaneous edges on 1 and 3
        irq_src = 4'b1010; tick;
        expect_out("e2_capture", 1'b0, 2'd2, 4'b1010, 1'b0);
        irq_src = 4'b0000; tick;
        expect_out("e2_req1", 1'b1, 2'd1, 4'b1010, 1'b0);
        trap_ack = 1'b1; tick;
        expect_out("e2_ack1", 1'b0, 2'd1, 4'b1000, 1'b1);
        trap_ack = 1'b0; mret_done = 1'b1; tick;
        expect_out("e2_mret", 1'b0, 2'd1, 4'b1000, 1'b0);
        mret_done = 1'b0; tick;
        expect_out("e2_req3", 1'b1, 2'd3, 4'b1000, 1'b0);

        // higher priority arrives while source 3 is offered
        irq_src = 4'b0001; tick;
        expect_out("e3_frozen", 1'b1, 2'd3, 4'b1001, 1'b0);
        irq_src = 4'b0000; trap_ack = 1'b1; tick;
        expect_out("e3_ack3", 1'b0, 2'd3, 4'b0001, 1'b1);
        trap_ack = 1'b0; mret_done = 1'b1; tick;
        expect_out("e3_mret", 1'b0, 2'd3, 4'b0001, 1'b0);
        mret_done = 1'b0; tick;
        expect_out("e3_req0", 1'b1, 2'd0, 4'b0001, 1'b0);
        trap_ack = 1'b1; tick;
        expect_out("e3_ack0", 1'b0, 2'd0, 4'b0000, 1'b1);
        trap_ack = 1'b0; mret_done = 1'b1; tick;
        mret_done = 1'b0;

        // withdrawal on global enable drop
        irq_src = 4'b0010; tick;
        irq_src = 4'b0000; tick;
        expect_out("e4_req", 1'b1, 2'd1, 4'b0010, 1'b0);
        mstatus_mie = 1'b0; tick;
        expect_out("e4_withdraw", 1'b0, 2'd1, 4'b0010, 1'b0);
        tick;
        expect_out("e4_gated", 1'b0, 2'd1, 4'b0010, 1'b0);
        mstatus_mie = 1'b1; tick;
        expect_out("e4_rereq", 1'b1, 2'd1, 4'b0010, 1'b0);

        // new edge on the same source as trap_ack
        irq_src = 4'b0010; trap_ack = 1'b1; tick;
        expect_out("e5_setwins", 1'b0, 2'd1, 4'b0010, 1'b1);
        irq_src = 4'b0000; trap_ack = 1'b0; mret_done = 1'b1; tick;
        expect_out("e5_mret", 1'b0, 2'd1, 4'b0010, 1'b0);
        mret_done = 1'b0; tick;
        expect_out("e5_reoffer", 1'b1, 2'd1, 4'b0010, 1'b0);
        trap_ack = 1'b1; tick;
        expect_out("e5_ack", 1'b0, 2'd1, 4'b0000, 1'b1);
        trap_ack = 1'b0;
`else
        // level source 2, quiesced before MRET
        irq_src = 4'b0100; tick;
        expect_out("l1_capture", 1'b0, 2'd0, 4'b0100, 1'b0);
        tick;
        expect_out("l1_req", 1'b1, 2'd2, 4'b0100, 1'b0);
        trap_ack = 1'b1; tick;
        expect_out("l1_ack", 1'b0, 2'd2, 4'b0100, 1'b1);
        trap_ack = 1'b0; irq_src = 4'b0000; tick;
        expect_out("l1_quiesce", 1'b0, 2'd2, 4'b0000, 1'b1);
        mret_done = 1'b1; tick;
        expect_out("l1_mret", 1'b0, 2'd2, 4'b0000, 1'b0);
        mret_done = 1'b0; tick;
        expect_out("l1_idle", 1'b0, 2'd2, 4'b0000, 1'b0);

        // priority, then level removal withdraws
        irq_src = 4'b1010; tick;
        expect_out("l2_capture", 1'b0, 2'd2, 4'b1010, 1'b0);
        tick;
        expect_out("l2_req1", 1'b1, 2'd1, 4'b1010, 1'b0);
        irq_src = 4'b1000; tick;
        expect_out("l2_lag", 1'b1, 2'd1, 4'b1000, 1'b0);
        tick;
        expect_out("l2_withdraw", 1'b0, 2'd1, 4'b1000, 1'b0);
        tick;
        expect_out("l2_req3", 1'b1, 2'd3, 4'b1000, 1'b0);

        // mask drop withdraws and blocks
        mie_mask = 4'b0111; tick;
        expect_out("l3_maskdrop", 1'b0, 2'd3, 4'b1000, 1'b0);
        tick;
        expect_out("l3_masked", 1'b0, 2'd3, 4'b1000, 1'b0);
        mie_mask = 4'b1111; irq_src = 4'b1001; tick;
        expect_out("l3_req3", 1'b1, 2'd3, 4'b1001, 1'b0);
        tick;
        expect_out("l3_frozen", 1'b1, 2'd3, 4'b1001, 1'b0);
        trap_ack = 1'b1; tick;
        expect_out("l3_ack", 1'b0, 2'd3, 4'b1001, 1'b1);
        trap_ack = 1'b0; irq_src = 4'b0001; tick;
        expect_out("l3_svc", 1'b0, 2'd3, 4'b0001, 1'b1);
        mret_done = 1'b1; tick;
        expect_out("l3_mret", 1'b0, 2'd3, 4'b0001, 1'b0);
        mret_done = 1'b0; tick;
        expect_out("l3_req0", 1'b1, 2'd0, 4'b0001, 1'b0);
        trap_ack = 1'b1; tick;
        expect_out("l3_ack0", 1'b0, 2'd0, 4'b0001, 1'b1);
        trap_ack = 1'b0;

        // global enable gates a held source in IDLE
        rst = 1'b0; #1;
        rst = 1'b1;
        mstatus_mie = 1'b0; tick;
        tick;
        expect_out("l4_gated", 1'b0, 2'd0, 4'b0001, 1'b0);
        mstatus_mie = 1'b1; tick;
        expect_out("l4_req0", 1'b1, 2'd0, 4'b0001, 1'b0);
        trap_ack = 1'b1; tick;
        expect_out("l4_ack0", 1'b0, 2'd0, 4'b0001, 1'b1);
        trap_ack = 1'b0;
`endif

        // asynchronous reset in SERVICE
        irq_src = 4'b0000;
        rst = 1'b0; #1;
        expect_out("rst_in_service", 1'b0, 2'd0, 4'b0000, 1'b0);
        #2 rst = 1'b1;
        tick;
        expect_out("rst_release", 1'b0, 2'd0, 4'b0000, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
